imm_encoder: RTL and testbench
==============================

# imm_encoder

Immediate encoder for the RV32 datapath: the inverse of the immediate extender. It takes a 32-bit immediate value, a format code and a base instruction word, and scatters the immediate into that format's instruction bit fields. It also flags values the format cannot represent. Used by the branch/jump patcher and the program-loader self-test path. Transfers use a valid/ready handshake with one registered output stage, plus handshake statistics counters.

## Interface
Parameters:
- CNT_W, 16, width of the EncCount and ErrCount statistics counters.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- InValid  in  1  input beat valid.
- InReady  out  1  block can accept an input beat.
- BaseInstr  in  32  instruction word. Opcode, rd, rs1, rs2 and funct fields are passed through; immediate fields are overwritten.
- Imm  in  32  immediate value, two's complement, in bytes for B/J.
- ImmControl  in  3  format code: 0=I, 1=S, 2=B, 3=J, 4=U; 5–7 are illegal.
- OutValid  out  1  output beat valid.
- OutReady  in  1  downstream accepts the output beat.
- Instr  out  32  encoded instruction.
- RangeErr  out  1  qualifies the current output beat: the immediate was not representable.
- EncCount  out  CNT_W  number of completed output handshakes.
- ErrCount  out  CNT_W  number of completed output handshakes with RangeErr=1.

## Operation
- Field mapping. Bits not listed come from BaseInstr.
  - I: [31:20]=Imm[11:0].
  - S: [31:25]=Imm[11:5]; [11:7]=Imm[4:0].
  - B: [31]=Imm[12]; [7]=Imm[11]; [30:25]=Imm[10:5]; [11:8]=Imm[4:1].
  - J: [31]=Imm[20]; [19:12]=Imm[19:12]; [20]=Imm[11]; [30:21]=Imm[10:1].
  - U: [31:12]=Imm[31:12].
- Representability. RangeErr=1 when the condition fails:
  - I/S: Imm[31:11] all equal.
  - B: Imm[31:12] all equal and Imm[0]=0.
  - J: Imm[31:20] all equal and Imm[0]=0.
  - U: Imm[11:0]=0.
- On error the beat is still emitted. Fields hold the truncated bits as mapped above, with RangeErr=1.
- Illegal ImmControl (5–7): Instr=BaseInstr unchanged, RangeErr=1.
- State machine, two states:
  - EMPTY (OutValid=0). Input handshake → FULL.
  - FULL (OutValid=1). Output handshake with no input handshake → EMPTY. Output handshake with an input handshake in the same cycle → stay FULL, register loads the new beat. No output handshake → hold.
- InReady = !rst && (state==EMPTY || OutReady). This is combinational, giving one beat per cycle at full throughput.
- Counters update on each output handshake (OutValid && OutReady). EncCount +1; ErrCount +1 if RangeErr. Both wrap modulo 2^CNT_W.

## Timing
- Latency 1 cycle: a beat accepted at edge N is presented with OutValid=1 after edge N.
- While OutValid=1 and OutReady=0, Instr and RangeErr are held stable and InReady=0.
- Beats are emitted in acceptance order. None are dropped or duplicated outside reset.
- Reset values, applied at the first edge with rst=1: OutValid=0, Instr=0, RangeErr=0, EncCount=0, ErrCount=0, state=EMPTY.
- InReady=0 during the cycle rst is high.
- Reset mid-operation: a held beat is discarded and not counted. No input is accepted in the reset cycle.
- Inputs are sampled only when InValid && InReady. Input values at other times are ignored.

## Test plan
- I-format, no backpressure: BaseInstr=0x00000093, Imm=0xFFFFF800, ImmControl=0 → one cycle later Instr=0x80000093, RangeErr=0. Imm=0x00000800 → RangeErr=1, Instr=0x80000093.
- B-format: BaseInstr=0x00000063, Imm=0x00000010, ImmControl=2 → Instr=0x00000863, RangeErr=0. Imm=0x00000011 → RangeErr=1.
- J and U formats:
  - J: BaseInstr=0x0000006F, Imm=0x00000800 → Instr=0x0010006F; Imm=0x00100000 → RangeErr=1.
  - U: BaseInstr=0x00000037, Imm=0x12345000 → Instr=0x12345037; Imm=0x12345001 → Instr=0x12345037, RangeErr=1.
- Illegal code: ImmControl=6, BaseInstr=0xDEADBEEF → Instr=0xDEADBEEF, RangeErr=1, ErrCount increments on the handshake.
- Backpressure and streaming:
  - Present two beats back-to-back with OutReady=0 for 3 cycles → first beat held stable, InReady=0, second beat not taken.
  - Then OutReady=1 → both beats emerge in order on consecutive cycles, EncCount=2.
  - Continuous InValid=1 with OutReady=1 → one beat per cycle.
- Reset mid-operation: rst=1 for one cycle while OutValid=1 and OutReady=0 → next cycle OutValid=0, EncCount=ErrCount=0, and the held beat never appears.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: RV32 immediate encoder, the inverse of the immediate extender.
// It scatters a 32-bit immediate into the I/S/B/J/U bit fields of a base
// instruction word and flags immediates the chosen format cannot hold.
// A single registered output stage sits behind a valid/ready handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   InValid/InReady          input handshake (InReady is combinational)
//   BaseInstr, Imm           base instruction word and immediate value
//   ImmControl               format: 0=I 1=S 2=B 3=J 4=U, 5-7 illegal
//   OutValid/OutReady        output handshake
//   Instr, RangeErr          encoded instruction, not-representable flag
//   EncCount, ErrCount       completed output handshakes / ones with RangeErr
module imm_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      BaseInstr,
  input  logic [31:0]      Imm,
  input  logic [2:0]       ImmControl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [31:0]      Instr,
  output logic             RangeErr,
  output logic [CNT_W-1:0] EncCount,
  output logic [CNT_W-1:0] ErrCount
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_J = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic             range_err_q, range_err_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [31:0]      enc_instr_c;
  logic             enc_err_c;
  logic             in_hs_c;
  logic             out_hs_c;

  // Field scatter and representability check for the incoming beat.
  // "All equal" over a sign-extension run means all ones or all zeros.
  always_comb begin
    enc_instr_c = BaseInstr;
    enc_err_c   = 1'b0;
    case (ImmControl)
      FMT_I: begin
        enc_instr_c[31:20] = Imm[11:0];
        enc_err_c          = !((&Imm[31:11]) || !(|Imm[31:11]));
      end
      FMT_S: begin
        enc_instr_c[31:25] = Imm[11:5];
        enc_instr_c[11:7]  = Imm[4:0];
        enc_err_c          = !((&Imm[31:11]) || !(|Imm[31:11]));
      end
      FMT_B: begin
        enc_instr_c[31]    = Imm[12];
        enc_instr_c[7]     = Imm[11];
        enc_instr_c[30:25] = Imm[10:5];
        enc_instr_c[11:8]  = Imm[4:1];
        enc_err_c          = !((&Imm[31:12]) || !(|Imm[31:12])) || Imm[0];
      end
      FMT_J: begin
        enc_instr_c[31]    = Imm[20];
        enc_instr_c[19:12] = Imm[19:12];
        enc_instr_c[20]    = Imm[11];
        enc_instr_c[30:21] = Imm[10:1];
        enc_err_c          = !((&Imm[31:20]) || !(|Imm[31:20])) || Imm[0];
      end
      FMT_U: begin
        enc_instr_c[31:12] = Imm[31:12];
        enc_err_c          = |Imm[11:0];
      end
      default: begin
        enc_err_c = 1'b1;
      end
    endcase
  end

  // Ready whenever the stage is empty or drains this cycle; never during reset.
  assign InReady  = !rst && ((state_q == EMPTY) || OutReady);
  assign in_hs_c  = InValid && InReady;
  assign out_hs_c = (state_q == FULL) && OutReady;

  // Next-state and datapath/counter update.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    range_err_d = range_err_q;
    enc_cnt_d   = enc_cnt_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      EMPTY: begin
        if (in_hs_c) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_hs_c && !in_hs_c) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (in_hs_c) begin
      instr_d     = enc_instr_c;
      range_err_d = enc_err_c;
    end

    if (out_hs_c) begin
      enc_cnt_d = enc_cnt_q + CNT_W'(1);
      if (range_err_q) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      instr_q     <= 32'd0;
      range_err_q <= 1'b0;
      enc_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      range_err_q <= range_err_d;
      enc_cnt_q   <= enc_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign OutValid = (state_q == FULL);
  assign Instr    = instr_q;
  assign RangeErr = range_err_q;
  assign EncCount = enc_cnt_q;
  assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_imm_encoder;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             InValid;
  logic             InReady;
  logic [31:0]      BaseInstr;
  logic [31:0]      Imm;
  logic [2:0]       ImmControl;
  logic             OutValid;
  logic             OutReady;
  logic [31:0]      Instr;
  logic             RangeErr;
  logic [CNT_W-1:0] EncCount;
  logic [CNT_W-1:0] ErrCount;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .InValid    (InValid),
    .InReady    (InReady),
    .BaseInstr  (BaseInstr),
    .Imm        (Imm),
    .ImmControl (ImmControl),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .Instr      (Instr),
    .RangeErr   (RangeErr),
    .EncCount   (EncCount),
    .ErrCount   (ErrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference encoder written from the format tables with masks and shifts;
  // range rules are expressed as signed intervals and alignment.
  typedef struct {
    logic [31:0] instr;
    bit          err;
  } beat_t;

  function automatic beat_t ref_enc(input logic [31:0] base, input logic [31:0] imm,
                                    input logic [2:0] ctl);
    beat_t r;
    int s;
    s = $signed(imm);
    r.instr = base;
    r.err   = 1'b1;
    case (ctl)
      3'd0: begin
        r.instr = (base & ~32'hFFF0_0000) | (imm << 20);
        r.err   = !(s >= -2048 && s <= 2047);
      end
      3'd1: begin
        r.instr = (base & ~32'hFE00_0F80) | (((imm >> 5) & 32'h7F) << 25)
                | ((imm & 32'h1F) << 7);
        r.err   = !(s >= -2048 && s <= 2047);
      end
      3'd2: begin
        r.instr = (base & ~32'hFE00_0F80) | (((imm >> 12) & 32'h1) << 31)
                | (((imm >> 11) & 32'h1) << 7) | (((imm >> 5) & 32'h3F) << 25)
                | (((imm >> 1) & 32'hF) << 8);
        r.err   = !(s >= -4096 && s <= 4095) || (imm % 2 != 0);
      end
      3'd3: begin
        r.instr = (base & ~32'hFFFF_F000) | (((imm >> 20) & 32'h1) << 31)
                | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                | (((imm >> 1) & 32'h3FF) << 21);
        r.err   = !(s >= -(1 << 20) && s <= (1 << 20) - 1) || (imm % 2 != 0);
      end
      3'd4: begin
        r.instr = (base & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
        r.err   = (imm % 4096) != 0;
      end
      default: begin
        r.instr = base;
        r.err   = 1'b1;
      end
    endcase
    return r;
  endfunction

  // Model state: beats held by the stage, plus handshake counters.
  beat_t mq[$];
  int    m_enc;
  int    m_err;
  bit    model_ok = 1'b0;
  bit    exp_rdy;
  beat_t head;

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    exp_rdy = !rst && (mq.size() == 0 || OutReady);
    if (model_ok) begin
      check("in_ready", 32'(InReady), 32'(exp_rdy));
      check("out_valid", 32'(OutValid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        head = mq[0];
        check("instr", Instr, head.instr);
        check("range_err", 32'(RangeErr), 32'(head.err));
      end
      check("enc_count", 32'(EncCount), 32'(m_enc % 65536));
      check("err_count", 32'(ErrCount), 32'(m_err % 65536));
    end
    if (rst) begin
      mq.delete();
      m_enc    = 0;
      m_err    = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (mq.size() != 0 && OutReady) begin
        m_enc++;
        if (mq[0].err) m_err++;
        void'(mq.pop_front());
      end
      if (InValid && exp_rdy) mq.push_back(ref_enc(BaseInstr, Imm, ImmControl));
    end
  end

  // Single beat with no backpressure; checks the registered result one edge later.
  task automatic send_one(input string name, input logic [31:0] base, input logic [31:0] imm,
                          input logic [2:0] ctl, input logic [31:0] exp_instr,
                          input logic exp_err);
    InValid    = 1'b1;
    BaseInstr  = base;
    Imm        = imm;
    ImmControl = ctl;
    OutReady   = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    check({name, "_valid"}, 32'(OutValid), 32'd1);
    check({name, "_instr"}, Instr, exp_instr);
    check({name, "_err"}, 32'(RangeErr), 32'(exp_err));
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] v;
    int unsigned k;
    case ($urandom_range(0, 5))
      0: v = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: v = $urandom;
      2: v = $urandom & 32'hFFFF_F000;
      3: v = 32'd1 << $urandom_range(0, 31);
      4: begin
        k = $urandom_range(0, 11);
        case (k)
          0: v = 32'd2047;       1: v = 32'd2048;
          2: v = 32'hFFFF_F800;  3: v = 32'hFFFF_F7FF;
          4: v = 32'd4094;       5: v = 32'd4096;
          6: v = 32'hFFFF_F000;  7: v = 32'hFFFF_EFFE;
          8: v = 32'h000F_FFFE;  9: v = 32'h0010_0000;
          10: v = 32'hFFF0_0000; default: v = 32'hFFEF_FFFE;
        endcase
      end
      default: v = 32'($urandom_range(0, 32'h003F_FFFF)) - 32'h0020_0000;
    endcase
    return v;
  endfunction

  initial begin
    rst        = 1'b1;
    InValid    = 1'b0;
    OutReady   = 1'b0;
    BaseInstr  = 32'd0;
    Imm        = 32'd0;
    ImmControl = 3'd0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", 32'(InReady), 32'd0);
    check("rst_out_valid", 32'(OutValid), 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_counts", {EncCount, ErrCount}, 32'd0);
    rst = 1'b0;

    // Backpressure: beat A held three cycles while beat B waits.
    InValid = 1'b1; OutReady = 1'b0;
    BaseInstr = 32'h0000_0013; Imm = 32'd5; ImmControl = 3'd0;
    @(posedge clk); #1;
    BaseInstr = 32'h0000_0037; Imm = 32'hABCD_E000; ImmControl = 3'd4;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_instr", Instr, 32'h0050_0013);
      check("bp_in_ready", 32'(InReady), 32'd0);
      @(posedge clk); #1;
    end
    check("bp_hold_last", Instr, 32'h0050_0013);
    OutReady = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    check("bp_second", Instr, 32'hABCD_E037);
    check("bp_second_valid", 32'(OutValid), 32'd1);
    @(posedge clk); #1;
    check("bp_drained", 32'(OutValid), 32'd0);
    check("bp_enc_count", 32'(EncCount), 32'd2);

    // Per-format directed beats.
    send_one("i_ok",  32'h0000_0093, 32'hFFFF_F800, 3'd0, 32'h8000_0093, 1'b0);
    send_one("i_err", 32'h0000_0093, 32'h0000_0800, 3'd0, 32'h8000_0093, 1'b1);
    send_one("b_ok",  32'h0000_0063, 32'h0000_0010, 3'd2, 32'h0000_0863, 1'b0);
    send_one("b_err", 32'h0000_0063, 32'h0000_0011, 3'd2, 32'h0000_0863, 1'b1);
    send_one("j_ok",  32'h0000_006F, 32'h0000_0800, 3'd3, 32'h0010_006F, 1'b0);
    send_one("j_err", 32'h0000_006F, 32'h0010_0000, 3'd3, 32'h8000_006F, 1'b1);
    send_one("u_ok",  32'h0000_0037, 32'h1234_5000, 3'd4, 32'h1234_5037, 1'b0);
    send_one("u_err", 32'h0000_0037, 32'h1234_5001, 3'd4, 32'h1234_5037, 1'b1);
    send_one("s_ok",  32'h0000_2023, 32'hFFFF_FFFC, 3'd1, 32'hFE00_2E23, 1'b0);
    send_one("ill",   32'hDEAD_BEEF, 32'h0000_0000, 3'd6, 32'hDEAD_BEEF, 1'b1);
    @(posedge clk); #1;
    check("ill_enc_count", 32'(EncCount), 32'd12);
    check("ill_err_count", 32'(ErrCount), 32'd5);

    // Full-throughput streaming.
    InValid = 1'b1; OutReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      BaseInstr = $urandom; Imm = rand_imm(); ImmControl = 3'($urandom_range(0, 4));
      @(posedge clk); #1;
      check("stream_valid", 32'(OutValid), 32'd1);
    end
    InValid = 1'b0;
    @(posedge clk); #1;
    check("stream_enc_count", 32'(EncCount), 32'd32);

    // Reset while a beat is held under backpressure.
    InValid = 1'b1; OutReady = 1'b0;
    BaseInstr = 32'h0000_0013; Imm = 32'd7; ImmControl = 3'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    BaseInstr = 32'h0000_0037; Imm = 32'h1111_1000; ImmControl = 3'd4;
    #1;
    check("midrst_in_ready", 32'(InReady), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    check("midrst_out_valid", 32'(OutValid), 32'd0);
    check("midrst_counts", {EncCount, ErrCount}, 32'd0);
    @(posedge clk); #1;
    check("midrst_no_ghost", 32'(OutValid), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      InValid    = ($urandom_range(0, 9) < 7);
      OutReady   = ($urandom_range(0, 9) < 6);
      BaseInstr  = $urandom;
      Imm        = rand_imm();
      ImmControl = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    rst = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
